// File: rtl/ula_multdiv.sv
// rtl/ula_multdiv.sv - iterative HI/LO multiply/divide unit (shift-add multiply, restoring divide)
module ula_multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       OpSelect,
  input  logic [WIDTH-1:0] entrada1,
  input  logic [WIDTH-1:0] entrada2,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] aux;
  logic [WIDTH-1:0] b_reg;
  logic             op_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_by_zero;

  logic               sgn_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy = (state != IDLE);

  // Signed ops iterate on magnitudes; the most-negative value maps onto itself as unsigned.
  always_comb begin
    sgn_op    = OpSelect[0];
    a_neg     = sgn_op && entrada1[WIDTH-1];
    b_neg     = sgn_op && entrada2[WIDTH-1];
    a_mag     = a_neg ? -entrada1 : entrada1;
    b_mag     = b_neg ? -entrada2 : entrada2;
    mul_add   = aux[0] ? b_reg : '0;
    mul_sum   = acc + {1'b0, mul_add};
    rem_shift = {acc[WIDTH-1:0], aux[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, b_reg};
    prod      = {acc[WIDTH-1:0], aux};
    prod_fix  = neg_q ? -prod : prod;
    quo_fix   = neg_q ? -aux : aux;
    rem_fix   = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      aux         <= '0;
      b_reg       <= '0;
      op_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
      div_zero    <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (OpSelect)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                state       <= RUN;
                cnt         <= '0;
                acc         <= '0;
                div_zero    <= 1'b0;
                op_div      <= OpSelect[1];
                neg_q       <= a_neg ^ b_neg;
                neg_r       <= a_neg && OpSelect[1];
                div_by_zero <= OpSelect[1] && (entrada2 == '0);
                // Multiply: aux holds the multiplier; divide: aux holds the dividend.
                aux         <= OpSelect[1] ? a_mag : b_mag;
                b_reg       <= OpSelect[1] ? b_mag : a_mag;
              end
              3'b100:  hi <= entrada1;
              3'b101:  lo <= entrada1;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (op_div) begin
            if (!rem_diff[WIDTH]) begin
              acc <= rem_diff;
              aux <= {aux[WIDTH-2:0], 1'b1};
            end else begin
              acc <= rem_shift;
              aux <= {aux[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= {1'b0, mul_sum[WIDTH:1]};
            aux <= {mul_sum[0], aux[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (op_div) begin
            if (div_by_zero) begin
              div_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
